// File: rtl/uart_rx_checked.sv
`timescale 1ns/1ps
// uart_rx_checked
//   8N1 UART receiver with mid-bit sampling, start-bit glitch rejection,
//   framing-error detection and a running 32-bit sum of accepted bytes.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   i_serial     serial line (idles high)
//   o_data       last accepted byte, held until the next accept
//   o_valid      one-cycle pulse: o_data holds a new byte
//   o_frame_err  one-cycle pulse: stop bit sampled low
//   o_sum        running sum of accepted bytes, wraps mod 2^32
//   o_busy       high whenever the receiver FSM is not idle
module uart_rx_checked #(
  parameter int unsigned cycles_per_bit = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_serial,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_frame_err,
  output logic [31:0] o_sum,
  output logic        o_busy
);

  localparam int unsigned HALF_CYCLES = cycles_per_bit / 2;
  localparam int unsigned CNT_W       = (cycles_per_bit > 1) ? $clog2(cycles_per_bit) : 1;

  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(cycles_per_bit - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic             sync1_r;
  logic             rx_r;
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       idx_r;
  logic [7:0]       shift_r;

  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [2:0]       idx_nxt_s;
  logic [7:0]       shift_nxt_s;
  logic [7:0]       data_nxt_s;
  logic [31:0]      sum_nxt_s;
  logic             valid_nxt_s;
  logic             ferr_nxt_s;

  // Busy is a direct decode of the state register.
  assign o_busy = (state_r != ST_IDLE);

  // Next-state, datapath and pulse decode; every branch starts from "hold".
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    shift_nxt_s = shift_r;
    data_nxt_s  = o_data;
    sum_nxt_s   = o_sum;
    valid_nxt_s = 1'b0;
    ferr_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Counting half a bit from the falling edge lands later samples mid-bit.
        if (rx_r == 1'b0) begin
          state_nxt_s = ST_START;
          cnt_nxt_s   = CNT_HALF;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == CNT_ZERO) begin
          if (rx_r == 1'b1) begin
            // Line went back high before mid start bit: treat as a glitch.
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DATA;
            idx_nxt_s   = 3'd0;
            cnt_nxt_s   = CNT_BIT;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_r == CNT_ZERO) begin
          shift_nxt_s[idx_r] = rx_r;
          cnt_nxt_s          = CNT_BIT;
          if (idx_r == 3'd7) begin
            state_nxt_s = ST_STOP;
          end else begin
            idx_nxt_s = idx_r + 3'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_STOP: begin
        // Returning to idle mid stop bit leaves half a bit of slack so a
        // start bit with no idle gap is still caught.
        if (cnt_r == CNT_ZERO) begin
          if (rx_r == 1'b1) begin
            data_nxt_s  = shift_r;
            sum_nxt_s   = o_sum + {24'd0, shift_r};
            valid_nxt_s = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            ferr_nxt_s  = 1'b1;
            state_nxt_s = ST_BREAK;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_BREAK: begin
        // Held-low line: wait for release so one break gives one error pulse.
        if (rx_r == 1'b1) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BREAK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
        idx_nxt_s   = 3'd0;
      end
    endcase
  end

  // Synchronizer, FSM state and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r     <= 1'b1;
      rx_r        <= 1'b1;
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      idx_r       <= 3'd0;
      shift_r     <= 8'd0;
      o_data      <= 8'd0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_sum       <= 32'd0;
    end else begin
      sync1_r     <= i_serial;
      rx_r        <= sync1_r;
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      idx_r       <= idx_nxt_s;
      shift_r     <= shift_nxt_s;
      o_data      <= data_nxt_s;
      o_valid     <= valid_nxt_s;
      o_frame_err <= ferr_nxt_s;
      o_sum       <= sum_nxt_s;
    end
  end

endmodule

// File: tb/tb_uart_rx_checked.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_rx_checked: one instance at 3 cycles/bit and
// one at 4 cycles/bit. Stimulus pushes expected pulses (kind, byte, sum,
// arrival cycle) and expected snapshots; one monitor process compares.
module tb_uart_rx_checked;

  localparam int unsigned CPB3 = 3;
  localparam int unsigned CPB4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst3_n, ser3, v3, f3, b3;
  logic [7:0]  d3;
  logic [31:0] s3;
  logic        rst4_n, ser4, v4, f4, b4;
  logic [7:0]  d4;
  logic [31:0] s4;

  uart_rx_checked #(.cycles_per_bit(CPB3)) u3 (
    .clk(clk), .rst_n(rst3_n), .i_serial(ser3), .o_data(d3), .o_valid(v3),
    .o_frame_err(f3), .o_sum(s3), .o_busy(b3));

  uart_rx_checked #(.cycles_per_bit(CPB4)) u4 (
    .clk(clk), .rst_n(rst4_n), .i_serial(ser4), .o_data(d4), .o_valid(v4),
    .o_frame_err(f4), .o_sum(s4), .o_busy(b4));

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          err;
    logic [7:0]  data;
    logic [31:0] sum;
    int unsigned at;
  } ev_t;

  typedef struct {
    int unsigned at;
    bit          is4;
    bit          busy;
    logic [7:0]  data;
    logic [31:0] sum;
  } st_t;

  ev_t q3[$];
  ev_t q4[$];
  st_t sq[$];

  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  // Model state owned by the stimulus process.
  logic [7:0]  md3, md4;
  logic [31:0] ms3, ms4;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input bit is4, input logic v, input logic f, input logic [7:0] d,
                     input logic [31:0] s, input logic pv, input logic pf);
    ev_t   e;
    string p;
    int    n;
    p = is4 ? "u4" : "u3";
    if (v || f) begin
      cmp({p, "_exclusive"}, {31'd0, v & f}, 32'd0);
      cmp({p, "_pulse_width"}, {31'd0, (v & pv) | (f & pf)}, 32'd0);
      if (is4) n = q4.size(); else n = q3.size();
      if (n == 0) begin
        checks++;
        failures++;
        $display("FAIL %s_unexpected_pulse actual valid=%0b frame_err=%0b required=none cycle=%0d",
                 p, v, f, cyc);
      end else begin
        if (is4) e = q4.pop_front(); else e = q3.pop_front();
        cmp({p, "_kind_frame_err"}, {31'd0, f}, {31'd0, e.err});
        cmp({p, "_data"}, {24'd0, d}, {24'd0, e.data});
        cmp({p, "_sum"}, s, e.sum);
        cmp({p, "_latency_cycle"}, cyc, e.at);
      end
    end
  endtask

  // Monitor: the only process that compares and counts.
  initial begin : monitor
    logic pv3, pf3, pv4, pf4;
    st_t  st;
    pv3 = 1'b0; pf3 = 1'b0; pv4 = 1'b0; pf4 = 1'b0;
    forever begin
      @(negedge clk);
      mon(1'b0, v3, f3, d3, s3, pv3, pf3);
      mon(1'b1, v4, f4, d4, s4, pv4, pf4);
      pv3 = v3; pf3 = f3; pv4 = v4; pf4 = f4;
      while (sq.size() > 0) begin
        if (sq[0].at > cyc) break;
        st = sq.pop_front();
        cmp("snapshot_cycle", cyc, st.at);
        if (st.is4) begin
          cmp("u4_snap_busy", {31'd0, b4}, {31'd0, st.busy});
          cmp("u4_snap_data", {24'd0, d4}, {24'd0, st.data});
          cmp("u4_snap_sum", s4, st.sum);
          cmp("u4_snap_pulses", {30'd0, v4, f4}, 32'd0);
        end else begin
          cmp("u3_snap_busy", {31'd0, b3}, {31'd0, st.busy});
          cmp("u3_snap_data", {24'd0, d3}, {24'd0, st.data});
          cmp("u3_snap_sum", s3, st.sum);
          cmp("u3_snap_pulses", {30'd0, v3, f3}, 32'd0);
        end
      end
      if (done || cyc > 20000) begin
        if (!done) begin
          checks++;
          failures++;
          $display("FAIL timeout actual=cycle %0d required=stimulus complete", cyc);
        end
        cmp("u3_missing_pulses", 32'(q3.size()), 32'd0);
        cmp("u4_missing_pulses", 32'(q4.size()), 32'd0);
        cmp("missing_snapshots", 32'(sq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  task automatic push_st(input bit is4, input int unsigned at, input bit busy,
                         input logic [7:0] data, input logic [31:0] sum);
    st_t st;
    st.at = at; st.is4 = is4; st.busy = busy; st.data = data; st.sum = sum;
    sq.push_back(st);
  endtask

  // Hold the line at b for n cycles, starting at the current falling edge.
  task automatic drive(input bit is4, input logic b, input int unsigned n);
    if (is4) ser4 = b; else ser3 = b;
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame; the expected pulse lands at t0 + 3 + half + 9*cpb.
  task automatic send(input bit is4, input logic [7:0] b, input logic stop_b);
    int unsigned cpb;
    ev_t         e;
    cpb   = is4 ? CPB4 : CPB3;
    e.at  = cyc + 3 + cpb / 2 + 9 * cpb;
    e.err = !stop_b;
    if (stop_b) begin
      if (is4) begin md4 = b; ms4 = ms4 + {24'd0, b}; end
      else     begin md3 = b; ms3 = ms3 + {24'd0, b}; end
    end
    e.data = is4 ? md4 : md3;
    e.sum  = is4 ? ms4 : ms3;
    if (is4) q4.push_back(e); else q3.push_back(e);
    drive(is4, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive(is4, b[i], cpb);
    drive(is4, stop_b, cpb);
  endtask

  // One-cycle reset; everything reads zero on the following cycle.
  task automatic pulse_reset(input bit is4);
    push_st(is4, cyc + 1, 1'b0, 8'h00, 32'h0000_0000);
    if (is4) rst4_n = 1'b0; else rst3_n = 1'b0;
    @(negedge clk);
    if (is4) begin rst4_n = 1'b1; md4 = 8'h00; ms4 = 32'd0; end
    else     begin rst3_n = 1'b1; md3 = 8'h00; ms3 = 32'd0; end
  endtask

  initial begin : stimulus
    logic [7:0] hello [5];
    int unsigned t0;
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    rst3_n = 1'b0; rst4_n = 1'b0; ser3 = 1'b1; ser4 = 1'b1;
    md3 = 8'h00; md4 = 8'h00; ms3 = 32'd0; ms4 = 32'd0;
    push_st(1'b0, 2, 1'b0, 8'h00, 32'h0000_0000);
    push_st(1'b1, 2, 1'b0, 8'h00, 32'h0000_0000);
    repeat (4) @(negedge clk);
    rst3_n = 1'b1; rst4_n = 1'b1;
    repeat (3) @(negedge clk);

    // 3 cycles/bit: single 0x55 with one idle bit after.
    send(1'b0, 8'h55, 1'b1);
    drive(1'b0, 1'b1, CPB3);
    drive(1'b0, 1'b1, 6);
    pulse_reset(1'b0);
    drive(1'b0, 1'b1, 3);
    // "Hello" back-to-back, no idle gap; final sum 0x1F4.
    foreach (hello[i]) send(1'b0, hello[i], 1'b1);
    drive(1'b0, 1'b1, 6);

    // 4 cycles/bit: one-cycle glitch is rejected.
    push_st(1'b1, cyc + 4, 1'b1, md4, ms4);
    push_st(1'b1, cyc + 8, 1'b0, md4, ms4);
    drive(1'b1, 1'b0, 1);
    drive(1'b1, 1'b1, 12);

    // Good byte so the framing error has non-zero data/sum to preserve.
    send(1'b1, 8'h3C, 1'b1);
    drive(1'b1, 1'b1, 4);
    send(1'b1, 8'hA3, 1'b0);
    push_st(1'b1, cyc + 10, 1'b1, md4, ms4);
    drive(1'b1, 1'b0, 30);
    drive(1'b1, 1'b1, 8);
    send(1'b1, 8'h01, 1'b1);
    drive(1'b1, 1'b1, 4);

    // Reset during data bit 4 of 0xFF, then 0x7E from a clean state.
    t0 = cyc;
    drive(1'b1, 1'b0, CPB4);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, CPB4);
    drive(1'b1, 1'b1, 1);
    pulse_reset(1'b1);
    drive(1'b1, 1'b1, (t0 + 10 * CPB4 + 8) - cyc);
    send(1'b1, 8'h7E, 1'b1);
    drive(1'b1, 1'b1, 4);

    // Sum wrap: preload 0xFFFFFF80, then 0x80 brings it to zero.
    force u4.o_sum = 32'hFFFF_FF80;
    @(negedge clk);
    release u4.o_sum;
    ms4 = 32'hFFFF_FF80;
    drive(1'b1, 1'b1, 2);
    send(1'b1, 8'h80, 1'b1);
    drive(1'b1, 1'b1, 6);

    done = 1'b1;
  end

endmodule

// File: doc/uart_rx_checked.md
Name: uart_rx_checked

Overview:
Serial UART receiver that sits directly downstream of the UART transmitter inside uart_top. It consumes the tx serial line and recovers 8N1 bytes using mid-bit sampling. It rejects start-bit glitches and flags framing errors. It keeps a running 32-bit checksum of accepted bytes, which the bench compares against a golden value at end of test.

Parameters:
cycles_per_bit, 4, clock cycles per serial bit. Legal values are ≥ 2. half = cycles_per_bit/2, using integer division.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous, active-low reset
i_serial  input  1  serial line; idles high
o_data  output  8  last accepted byte; held until next accept
o_valid  output  1  one-cycle pulse: o_data is a new byte
o_frame_err  output  1  one-cycle pulse: stop bit sampled low
o_sum  output  32  running sum of accepted bytes, wraps mod 2^32
o_busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (rst_n low at posedge clk) sets:
  - o_data=0, o_valid=0, o_frame_err=0, o_sum=0, o_busy=0
  - FSM=IDLE, counters=0
  - both synchronizer flops=1
- Reset has priority over everything; reset mid-byte discards the partial byte.
- Input synchronizer:
  - 2-flop synchronizer on i_serial; the FSM sees only the second flop (rx).
  - Adds 2 cycles of latency.
- FSM states and transitions:
  - IDLE: when rx==0, go to START and load the cycle counter with half-1.
  - START: count down to 0, then sample rx.
    - rx==1: glitch; return to IDLE with no pulse.
    - rx==0: go to DATA with bit index=0 and counter=cycles_per_bit-1.
  - DATA: at counter==0, sample rx into shift[bit index], LSB first.
    - After bit 7, go to STOP with counter=cycles_per_bit-1.
    - Otherwise reload the counter.
  - STOP: at counter==0, sample rx.
    - rx==1: register o_data=shift and o_sum=o_sum+shift; pulse o_valid next cycle; go to IDLE.
    - rx==0: pulse o_frame_err next cycle; o_data and o_sum unchanged; go to BREAK.
  - BREAK: wait until rx==1, then go to IDLE. A held-low line yields exactly one o_frame_err.
- Timing:
  - Let t0 be the first cycle i_serial is low at the pin.
  - Stop sample occurs at t0 + 2 + half + 9*cycles_per_bit.
  - o_valid / o_frame_err are high on the following cycle.
- Back-to-back bytes:
  - IDLE is re-entered in the middle of the stop bit.
  - A start bit immediately following the stop bit (no idle gap) must be received correctly.
- o_valid and o_frame_err are never high in the same cycle.
- Each pulse lasts exactly 1 cycle.
- Arithmetic: o_sum adds the zero-extended byte; overflow wraps silently.
- o_busy is combinational from the FSM state (high when state != IDLE).

Test Plan:
- cycles_per_bit=3, transmit 0x55 with one idle bit after → single o_valid, o_data=0x55, o_sum=0x00000055, no o_frame_err.
- cycles_per_bit=3, transmit "Hello" (0x48,0x65,0x6C,0x6C,0x6F) back-to-back with zero idle gap → five o_valid pulses in order, final o_sum=0x000001F4.
- cycles_per_bit=4, drive i_serial low for 1 cycle then high → no o_valid, no o_frame_err, o_busy returns low, o_sum unchanged.
- cycles_per_bit=4, send 0xA3 with stop bit low, then hold the line low 30 cycles → exactly one o_frame_err pulse, o_data/o_sum unchanged. Release the line, send 0x01 → o_valid, o_sum incremented by 1.
- Assert rst_n=0 for one cycle during data bit 4 of 0xFF → all outputs 0 next cycle, no o_valid for that byte. Then send 0x7E → o_data=0x7E, o_sum=0x0000007E.
- Preload o_sum near wrap: send 0xFF repeatedly (or force o_sum=0xFFFFFF80) then send 0x80 → o_sum=0x00000000, o_valid asserted.
